// File: rtl/regfile_multiport_init.sv
// rtl/regfile_multiport_init.sv - multi-port register file with write-through bypass and post-reset clear
module regfile_multiport_init #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_rs_p          = 3,
  parameter int num_ws_p          = 2,
  parameter int x0_tied_to_zero_p = 1,
  localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  output logic                              ready_o,
  input  logic [num_ws_p-1:0]               w_v_i,
  input  logic [num_ws_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_ws_p*width_p-1:0]       w_data_i,
  input  logic [num_rs_p-1:0]               r_v_i,
  input  logic [num_rs_p*addr_width_lp-1:0] r_addr_i,
  output logic [num_rs_p*width_p-1:0]       r_data_o
);

  if (num_rs_p < 1 || num_rs_p > 4) begin : g_bad_num_rs
    $error("regfile_multiport_init: num_rs_p must be 1..4");
  end
  if (num_ws_p < 1 || num_ws_p > 2) begin : g_bad_num_ws
    $error("regfile_multiport_init: num_ws_p must be 1..2");
  end

  localparam logic [0:0] init_s  = 1'b0;
  localparam logic [0:0] ready_s = 1'b1;
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  logic [0:0]               state;
  logic [addr_width_lp-1:0] init_cnt;
  logic                     ready;

  logic [num_ws_p-1:0][addr_width_lp-1:0] waddr;
  logic [num_ws_p-1:0][width_p-1:0]       wdata;
  logic [num_rs_p-1:0][addr_width_lp-1:0] raddr_in;
  logic [num_ws_p-1:0]                    we;

  logic [num_rs_p-1:0][addr_width_lp-1:0] raddr_r;
  logic [num_rs_p-1:0][addr_width_lp-1:0] raddr_n;
  logic [num_rs_p-1:0][width_p-1:0]       rdata_r;
  logic [num_rs_p-1:0][width_p-1:0]       rdata_n;

  logic [width_p-1:0] mem [els_p];

  assign waddr    = w_addr_i;
  assign wdata    = w_data_i;
  assign raddr_in = r_addr_i;
  assign ready    = (state == ready_s);
  assign ready_o  = ready;
  assign r_data_o = rdata_r;

  // The clear sequence walks every entry once, then the FSM parks in READY.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= init_s;
      init_cnt <= '0;
    end else if (state == init_s) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == last_addr_lp) begin
        state <= ready_s;
      end
    end
  end

  always_comb begin
    we = '0;
    for (int k = 0; k < num_ws_p; k++) begin
      we[k] = ready && w_v_i[k] &&
              !((x0_tied_to_zero_p != 0) && (waddr[k] == '0));
    end
  end

  // Storage has no reset; later ports are assigned last so port 1 wins a collision.
  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem[init_cnt] <= '0;
    end
    for (int k = 0; k < num_ws_p; k++) begin
      if (we[k]) begin
        mem[waddr[k]] <= wdata[k];
      end
    end
  end

  // Next read data is the post-write array image, so bypass mirrors the write priority.
  always_comb begin
    raddr_n = raddr_r;
    rdata_n = '0;
    for (int i = 0; i < num_rs_p; i++) begin
      raddr_n[i] = r_v_i[i] ? raddr_in[i] : raddr_r[i];
      rdata_n[i] = mem[raddr_n[i]];
      for (int k = 0; k < num_ws_p; k++) begin
        if (we[k] && (waddr[k] == raddr_n[i])) begin
          rdata_n[i] = wdata[k];
        end
      end
      if ((x0_tied_to_zero_p != 0) && (raddr_n[i] == '0)) begin
        rdata_n[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      raddr_r <= '0;
      rdata_r <= '0;
    end else if (ready) begin
      raddr_r <= raddr_n;
      rdata_r <= rdata_n;
    end
  end

endmodule
